twos_complement_seq_ctrl: RTL and testbench
===========================================

Name: twos_complement_seq_ctrl

Overview:
- Parallel-to-serial sequencer for the bit-serial two's complement converter FSM.
- Accepts a WIDTH-bit word over a valid/ready handshake and issues a one-cycle clear pulse to the converter.
- Streams the word LSB-first into the converter, collects the serial result back into a parallel word, and presents it with valid/ready plus status flags.
- Sits between a parallel producer/consumer and one instance of the serial converter.

Parameters:
- WIDTH, 8, word width in bits; legal range 2 to 32.
- CNT_W, 6, width of the internal bit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  controller can accept a word; high only in IDLE.
- in_data  input  WIDTH  operand, two's complement.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  negated operand, modulo 2^WIDTH.
- out_zero  output  1  operand was 0.
- out_ovf  output  1  operand was the most-negative value (1 followed by zeros); result equals operand.
- busy  output  1  high in every state except IDLE.
- conv_reset  output  1  drives the converter's reset input.
- conv_in  output  1  serial bit to the converter.
- conv_out  input  1  serial result from the converter; one-cycle registered latency from conv_in.

Behaviour:
- Reset values (reset high at a posedge):
  - State goes to IDLE.
  - out_valid, out_data, out_zero, out_ovf go to 0.
  - Internal shift/result registers and counter go to 0.
- Reset pass-through:
  - conv_reset = 1 combinationally whenever reset is high, so the converter clears with the controller.
  - Reset mid-operation abandons the word with no partial output.
  - in_ready = 1 on the first cycle after reset deasserts.
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE. Outputs are decoded from state and registers, with no combinational path from in_valid/out_ready to outputs.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load the operand shift register with in_data.
  - Register out_zero = (in_data == 0) and out_ovf = (in_data == 1 followed by WIDTH-1 zeros).
  - Clear the counter and go to CLEAR.
- CLEAR:
  - Exactly one cycle, conv_reset = 1, conv_in = 0.
  - Go to SHIFT.
- SHIFT:
  - Lasts WIDTH cycles, conv_in = operand shift register bit 0.
  - Operand register shifts right by one each cycle; the counter increments.
  - From the 2nd SHIFT cycle onward, each posedge captures conv_out into the MSB of the result register, shifting it right.
  - After the WIDTH-th cycle, go to DRAIN.
- DRAIN:
  - One cycle, conv_in = 0, captures the final conv_out bit, making WIDTH captures in total.
  - At the edge, out_data <= completed result and out_valid <= 1.
  - Go to DONE.
- DONE:
  - out_valid = 1; out_data and the flags are stable.
  - On out_ready = 1: clear out_valid at the edge and go to IDLE.
  - out_data and the flags retain their last value until the next DRAIN.
- conv_reset = 0 and conv_in = 0 in IDLE, DRAIN and DONE (reset aside).
- Latency: out_valid rises WIDTH+2 clocks after the accepting edge (10 for WIDTH = 8).
- Throughput: with out_ready held high, one word per WIDTH+4 clocks (IDLE, CLEAR, WIDTH×SHIFT, DRAIN, DONE).
- Boundary cases:
  - in_valid while busy is ignored, and in_data is not sampled.
  - out_ready while not in DONE has no effect.
  - Back-pressure holds DONE indefinitely with all outputs unchanged.
  - Arithmetic is modulo 2^WIDTH: the result for 0 is 0, and the result for the most-negative value is itself with out_ovf = 1.

Test Plan:
1. WIDTH=8, in_data=0x01, out_ready=1 -> conv_reset high exactly one cycle; out_valid rises 10 clocks after accept; out_data=0xFF, out_zero=0, out_ovf=0.
2. in_data=0x6C, then 0x00, then 0x80 back-to-back -> 0x94 (flags 0/0), 0x00 (out_zero=1), 0x80 (out_ovf=1); consecutive out_valid rises 12 clocks apart.
3. in_data=0x05 with out_ready=0 for 5 cycles after out_valid -> out_valid and out_data=0xFB held stable; in_ready=0 throughout; IDLE one cycle after out_ready=1.
4. in_valid pulsed with 0x33 during the 4th SHIFT cycle of operand 0x02 -> ignored; result 0xFE; no second result.
5. reset asserted for one cycle during the 3rd SHIFT cycle of operand 0x7F -> conv_reset=1 that cycle; out_valid never rises; in_ready=1 the next cycle; the next operand 0x10 yields 0xF0.
6. Random operands (1000 words) with random out_ready stalls -> out_data == (-in_data) mod 256 for every word; flags match.

Source files
------------

// File: rtl/twos_complement_seq_ctrl.sv
// twos_complement_seq_ctrl: parallel-to-serial sequencer around a bit-serial two's complement converter
module twos_complement_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             busy,
  output logic             conv_reset,
  output logic             conv_in,
  input  logic             conv_out
);
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-2:0] res;
  logic [CNT_W-1:0] cnt;
  logic zero_q, ovf_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sh        <= '0;
      res       <= '0;
      cnt       <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sh     <= in_data;
          zero_q <= in_data == '0;
          ovf_q  <= in_data == MIN;
          cnt    <= '0;
          state  <= CLEAR;
        end
        CLEAR: state <= SHIFT;
        SHIFT: begin
          sh  <= sh >> 1;
          cnt <= cnt + CNT_W'(1);
          // converter output lags by one cycle, so the first SHIFT cycle has nothing to capture
          if (cnt != '0) res <= (WIDTH-1)'({conv_out, res} >> 1);
          if (cnt == LAST) state <= DRAIN;
        end
        DRAIN: begin
          out_data  <= {conv_out, res};
          out_zero  <= zero_q;
          out_ovf   <= ovf_q;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign in_ready   = state == IDLE;
  assign busy       = state != IDLE;
  assign conv_reset = reset | (state == CLEAR);
  assign conv_in    = (state == SHIFT) & sh[0];
endmodule

// File: tb/tb_twos_complement_seq_ctrl.sv
// tb_twos_complement_seq_ctrl: randomized self-checking bench with a behavioural serial converter model
module tb_twos_complement_seq_ctrl;
  localparam int W = 8;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, out_zero, out_ovf, busy, conv_reset, conv_in;
  logic [W-1:0] out_data;
  logic conv_out = 0, seen = 0;
  int n_checks = 0, n_fail = 0;

  twos_complement_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero),
    .out_ovf(out_ovf), .busy(busy), .conv_reset(conv_reset), .conv_in(conv_in), .conv_out(conv_out)
  );

  always #5 clk = ~clk;

  // serial negation: each output bit is the input bit inverted once any lower bit was 1
  always @(posedge clk) begin
    if (conv_reset) begin
      seen <= 0;
      conv_out <= 0;
    end else begin
      conv_out <= conv_in ^ seen;
      seen <= seen | conv_in;
    end
  end

  function automatic logic [W+1:0] ref_result(input logic [W-1:0] x);
    logic [W-1:0] n;
    n = W'((1 << W) - int'(x));
    return {n, x == 0, x == (1 << (W - 1))};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    int i;
    in_valid = 1;
    in_data = d;
    for (i = 0; i < 100 && !in_ready; i++) step();
    n_checks++;
    if (!in_ready) begin n_fail++; $display("FAIL send_timeout in_ready=%0b required 1", in_ready); end
    step();
    in_valid = 0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin step(); cyc++; end
    n_checks++;
    if (!out_valid) begin n_fail++; $display("FAIL wait_valid_timeout out_valid=%0b required 1", out_valid); end
  endtask

  task automatic check_result(input string name, input logic [W-1:0] x);
    logic [W+1:0] e;
    e = ref_result(x);
    n_checks++;
    if ({out_data, out_zero, out_ovf} !== e) begin
      n_fail++;
      $display("FAIL %s data/zero/ovf=%h/%b/%b required %h/%b/%b", name, out_data, out_zero, out_ovf,
               e[W+1:2], e[1], e[0]);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    step();
    n_checks++;
    if (conv_reset !== 1) begin n_fail++; $display("FAIL reset_conv_reset got %b required 1", conv_reset); end
    step();
    reset = 0;
    #1;
    n_checks++;
    if ({out_valid, out_data, out_zero, out_ovf, in_ready, busy, conv_reset, conv_in} !== {1'b0, 8'h00, 4'b0010, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state valid=%b data=%h z=%b o=%b rdy=%b busy=%b cr=%b ci=%b required 0 00 0 0 1 0 0 0",
               out_valid, out_data, out_zero, out_ovf, in_ready, busy, conv_reset, conv_in);
    end
  endtask

  task automatic test_single();
    int cyc, clr;
    out_ready = 1;
    send(8'h01);
    cyc = 0;
    clr = 0;
    while (!out_valid && cyc < 100) begin
      if (conv_reset) clr++;
      step();
      cyc++;
    end
    n_checks++;
    if (cyc !== 10) begin n_fail++; $display("FAIL single_latency got %0d required 10", cyc); end
    n_checks++;
    if (clr !== 1) begin n_fail++; $display("FAIL single_clear_pulse got %0d required 1", clr); end
    check_result("single_result", 8'h01);
    step();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [3] = '{8'h6C, 8'h00, 8'h80};
    int idx, got, cyc;
    int rise [3];
    idx = 0;
    got = 0;
    out_ready = 1;
    for (cyc = 0; cyc < 200 && got < 3; cyc++) begin
      if (out_valid) begin
        rise[got] = cyc;
        check_result("b2b_result", words[got]);
        got++;
      end
      if (in_ready) begin
        in_valid = idx < 3;
        if (idx < 3) begin in_data = words[idx]; idx++; end
      end
      step();
    end
    in_valid = 0;
    n_checks++;
    if (got !== 3) begin n_fail++; $display("FAIL b2b_count got %0d required 3", got); end
    else begin
      n_checks++;
      if (rise[1] - rise[0] !== 12 || rise[2] - rise[1] !== 12) begin
        n_fail++;
        $display("FAIL b2b_spacing got %0d,%0d required 12,12", rise[1] - rise[0], rise[2] - rise[1]);
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready = 0;
    send(8'h05);
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid, out_data, in_ready} !== {1'b1, 8'hFB, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold valid=%b data=%h rdy=%b required 1 fb 0", out_valid, out_data, in_ready);
      end
      step();
    end
    check_result("bp_result", 8'h05);
    out_ready = 1;
    step();
    n_checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b0, 8'hFB}) begin
      n_fail++;
      $display("FAIL bp_release rdy=%b valid=%b data=%h required 1 0 fb", in_ready, out_valid, out_data);
    end
  endtask

  task automatic test_busy_ignore();
    int cyc, extra;
    out_ready = 1;
    send(8'h02);
    for (int i = 0; i < 4; i++) step();
    in_valid = 1;
    in_data = 8'h33;
    step();
    in_valid = 0;
    wait_valid(cyc);
    check_result("ignore_result", 8'h02);
    step();
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid || !in_ready) extra++;
      step();
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL ignore_second_result got %0d busy/valid cycles required 0", extra); end
  endtask

  task automatic test_mid_reset();
    int bad, cyc;
    out_ready = 1;
    send(8'h7F);
    for (int i = 0; i < 3; i++) step();
    reset = 1;
    #1;
    n_checks++;
    if (conv_reset !== 1) begin n_fail++; $display("FAIL midreset_conv_reset got %b required 1", conv_reset); end
    step();
    reset = 0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL midreset_idle rdy=%b valid=%b required 1 0", in_ready, out_valid);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) bad++;
      step();
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL midreset_no_output got %0d valid cycles required 0", bad); end
    send(8'h10);
    wait_valid(cyc);
    check_result("midreset_next", 8'h10);
    step();
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic [W-1:0] x;
    int sent, recv, cyc, r;
    sent = 0;
    recv = 0;
    for (cyc = 0; cyc < 50000 && recv < 1000; cyc++) begin
      out_ready = $urandom_range(1, 0) == 1;
      if (!(in_valid && in_ready)) begin
        in_valid = sent < 1000 && $urandom_range(3, 0) != 0;
        r = $urandom_range(15, 0);
        in_data = r == 0 ? 8'h00 : r == 1 ? 8'h80 : W'($urandom);
      end
      if (in_valid && in_ready) begin q.push_back(in_data); sent++; end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious data=%h required no output", out_data);
        end else begin
          x = q.pop_front();
          n_checks--;
          check_result("rand_result", x);
        end
        recv++;
      end
      step();
      if (in_valid && !in_ready && sent > 0) in_valid = in_valid;
    end
    in_valid = 0;
    n_checks++;
    if (recv !== 1000) begin n_fail++; $display("FAIL rand_count got %0d required 1000", recv); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_busy_ignore();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
